// File: rtl/riscv_pkg.sv
// Shared types and decode helpers for the RV32M multiply/divide sequencer.
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [3:0] {
    MD_NOP    = 4'd0,
    MD_MUL    = 4'd1,
    MD_MULH   = 4'd2,
    MD_MULHSU = 4'd3,
    MD_MULHU  = 4'd4,
    MD_DIV    = 4'd5,
    MD_DIVU   = 4'd6,
    MD_REM    = 4'd7,
    MD_REMU   = 4'd8
  } md_oper_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  // MUL keeps both operands signed; the low product word is the same either way.
  function automatic logic md_is_signed1(md_oper_t op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic md_is_signed2(md_oper_t op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic md_is_div(md_oper_t op);
    return (op == MD_DIV) || (op == MD_DIVU) || (op == MD_REM) || (op == MD_REMU);
  endfunction

  function automatic logic md_is_rem(md_oper_t op);
    return (op == MD_REM) || (op == MD_REMU);
  endfunction

  function automatic logic md_is_high(md_oper_t op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_MULHU);
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// EX-stage request/response bundle between the pipeline and the mul/div sequencer.
interface muldiv_seq_if;
  import riscv_pkg::*;

  logic            req_valid_i;
  md_oper_t        md_oper_i;
  logic [XLEN-1:0] operand1_i;
  logic [XLEN-1:0] operand2_i;
  logic            flush_i;
  logic            stall_ext_i;
  logic            stall_o;
  logic            busy_o;
  logic            result_valid_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output req_valid_i, md_oper_i, operand1_i, operand2_i, flush_i, stall_ext_i,
    input  stall_o, busy_o, result_valid_o, result_o
  );

  modport slave (
    input  req_valid_i, md_oper_i, operand1_i, operand2_i, flush_i, stall_ext_i,
    output stall_o, busy_o, result_valid_o, result_o
  );

endinterface

// File: rtl/md_iter_core.sv
// One iteration of the shared datapath: shift-add multiply step or restoring divide step.
module md_iter_core
  import riscv_pkg::*;
(
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   operand_i,
  input  logic              div_mode_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0]   mulSum;
  logic [XLEN:0]   remShift;
  logic [XLEN-1:0] remDiff;
  logic            remGeq;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
  // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left.
  always_comb begin
    acc_o    = acc_i;
    mulSum   = '0;
    remShift = '0;
    remDiff  = '0;
    remGeq   = 1'b0;
    if (div_mode_i) begin
      remShift = acc_i[2*XLEN-1:XLEN-1];
      remGeq   = (remShift >= {1'b0, operand_i});
      remDiff  = remShift[XLEN-1:0] - operand_i;
      if (remGeq) begin
        acc_o = {remDiff, acc_i[XLEN-2:0], 1'b1};
      end else begin
        acc_o = {remShift[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
      end
    end else begin
      mulSum = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, operand_i} : '0);
      acc_o  = {mulSum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer beside the EX ALU: 1 bit per cycle, stalls the
// front end while computing and offers the sign-corrected rd value for one capture.
module muldiv_seq
  import riscv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rstn_i,
  muldiv_seq_if.slave md
);

  md_state_t         state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  md_oper_t          oper_q, oper_d;
  logic              negate_q, negate_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [2*XLEN-1:0] accNext;
  logic [2*XLEN-1:0] prodFix;
  logic [XLEN-1:0]   divPick, divFix, finalVal;
  logic              sign1, sign2;
  logic [XLEN-1:0]   mag1, mag2;
  logic              isDivZero, isOverflow;
  logic [XLEN-1:0]   specialVal;

  md_iter_core u_core (
    .acc_i      (acc_q),
    .operand_i  (opnd_q),
    .div_mode_i (md_is_div(oper_q)),
    .acc_o      (accNext)
  );

  // Request decode: operand magnitudes and the cases that skip iteration entirely.
  always_comb begin
    sign1      = md_is_signed1(md.md_oper_i) & md.operand1_i[XLEN-1];
    sign2      = md_is_signed2(md.md_oper_i) & md.operand2_i[XLEN-1];
    mag1       = sign1 ? -md.operand1_i : md.operand1_i;
    mag2       = sign2 ? -md.operand2_i : md.operand2_i;
    isDivZero  = md_is_div(md.md_oper_i) && (md.operand2_i == '0);
    isOverflow = ((md.md_oper_i == MD_DIV) || (md.md_oper_i == MD_REM)) &&
                 (md.operand1_i == {1'b1, {(XLEN-1){1'b0}}}) && (md.operand2_i == '1);
    specialVal = '0;
    if (isDivZero) begin
      specialVal = md_is_rem(md.md_oper_i) ? md.operand1_i : '1;
    end else if (isOverflow) begin
      specialVal = md_is_rem(md.md_oper_i) ? '0 : md.operand1_i;
    end
  end

  always_comb begin
    prodFix  = negate_q ? -accNext : accNext;
    divPick  = md_is_rem(oper_q) ? accNext[2*XLEN-1:XLEN] : accNext[XLEN-1:0];
    divFix   = negate_q ? -divPick : divPick;
    finalVal = md_is_div(oper_q) ? divFix :
               (md_is_high(oper_q) ? prodFix[2*XLEN-1:XLEN] : prodFix[XLEN-1:0]);
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    oper_d   = oper_q;
    negate_d = negate_q;
    result_d = result_q;
    case (state_q)
      MD_IDLE: begin
        if (md.req_valid_i && !md.flush_i) begin
          oper_d   = md.md_oper_i;
          opnd_d   = mag2;
          acc_d    = {{XLEN{1'b0}}, mag1};
          negate_d = md_is_rem(md.md_oper_i) ? sign1 : (sign1 ^ sign2);
          if (isDivZero || isOverflow) begin
            result_d = specialVal;
            count_d  = '0;
            state_d  = MD_DONE;
          end else begin
            count_d = CNT_W'(XLEN - 1);
            state_d = MD_CALC;
          end
        end
      end
      MD_CALC: begin
        acc_d = accNext;
        if (count_q == '0) begin
          result_d = finalVal;
          state_d  = MD_DONE;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      MD_DONE: begin
        if (!md.stall_ext_i) begin
          state_d = MD_IDLE;
        end
      end
      default: state_d = MD_IDLE;
    endcase
    if (md.flush_i) begin
      state_d = MD_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= MD_IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      oper_q   <= MD_NOP;
      negate_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      oper_q   <= oper_d;
      negate_q <= negate_d;
      result_q <= result_d;
    end
  end

  assign md.stall_o        = !md.flush_i &&
                             (((state_q == MD_IDLE) && md.req_valid_i) || (state_q == MD_CALC));
  assign md.busy_o         = (state_q != MD_IDLE);
  assign md.result_valid_o = (state_q == MD_DONE);
  assign md.result_o       = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized self-checking bench for muldiv_seq against a plain-arithmetic RV32M model.
module tb_muldiv_seq;
  import riscv_pkg::*;

  logic clk_i;
  logic rstn_i;
  int   vectors;
  int   miscompares;

  muldiv_seq_if bus ();

  muldiv_seq dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .md     (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    md_oper_t    op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  // Reference: RV32M results straight from 64-bit arithmetic and the ISA special cases.
  function automatic logic [31:0] refModel(md_oper_t op, logic [31:0] a, logic [31:0] b);
    longint      sa, sb, ub, p;
    logic [63:0] pu;
    int          ia, ib;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'd0, b});
    ia  = int'(a);
    ib  = int'(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      MD_MUL:    begin p = sa * sb; return p[31:0]; end
      MD_MULH:   begin p = sa * sb; return p[63:32]; end
      MD_MULHSU: begin p = sa * ub; return p[63:32]; end
      MD_MULHU:  begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
      MD_DIV:    return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(ia / ib));
      MD_REM:    return (b == 0) ? a : (ovf ? 32'd0 : 32'(ia % ib));
      MD_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MD_REMU:   return (b == 0) ? a : a % b;
      default:   return 32'd0;
    endcase
  endfunction

  function automatic int refLatency(md_oper_t op, logic [31:0] a, logic [31:0] b);
    logic isDiv, isSignedDiv;
    isDiv       = (op == MD_DIV) || (op == MD_DIVU) || (op == MD_REM) || (op == MD_REMU);
    isSignedDiv = (op == MD_DIV) || (op == MD_REM);
    if (isDiv && b == 0) return 1;
    if (isSignedDiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom());
    endcase
  endfunction

  function automatic md_oper_t pickOper();
    return md_oper_t'(4'($urandom_range(1, 8)));
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Presents one request and watches it to completion; ends aligned one cycle after
  // the result cycle. lat is the cycle index of result_valid_o (-1 on timeout).
  task automatic issue(input md_oper_t op, input logic [31:0] a, input logic [31:0] b,
                       input bit garbage, output logic [31:0] res, output int lat,
                       output int stallCnt, output logic doneStall);
    bus.req_valid_i = 1'b1;
    bus.md_oper_i   = op;
    bus.operand1_i  = a;
    bus.operand2_i  = b;
    res       = 32'hDEAD_BEEF;
    lat       = -1;
    stallCnt  = 0;
    doneStall = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bus.result_valid_o) begin
        res       = bus.result_o;
        doneStall = bus.stall_o;
        lat       = c;
        break;
      end
      if (bus.stall_o) stallCnt++;
      tick();
      if (garbage) begin
        bus.md_oper_i  = pickOper();
        bus.operand1_i = 32'($urandom());
        bus.operand2_i = 32'($urandom());
      end else begin
        bus.req_valid_i = 1'b0;
      end
    end
    bus.req_valid_i = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    vectors++;
    if (bus.busy_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset busy_o: got %b, expected 0", bus.busy_o);
    end
    vectors++;
    if (bus.result_valid_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset result_valid_o: got %b, expected 0", bus.result_valid_o);
    end
    vectors++;
    if (bus.result_o !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset result_o: got %h, expected 0", bus.result_o);
    end
    vectors++;
    if (bus.stall_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset stall_o: got %b, expected 0", bus.stall_o);
    end
    rstn_i = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    vec_t        dv[$];
    logic [31:0] res;
    int          lat, stallCnt;
    logic        doneStall;
    dv.push_back('{MD_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
    dv.push_back('{MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
    dv.push_back('{MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33});
    dv.push_back('{MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
    dv.push_back('{MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1});
    dv.push_back('{MD_DIVU,   32'd20,        32'd0,         32'hFFFF_FFFF, 1});
    dv.push_back('{MD_REMU,   32'd20,        32'd0,         32'd20,        1});
    dv.push_back('{MD_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33});
    dv.push_back('{MD_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33});
    foreach (dv[i]) begin
      issue(dv[i].op, dv[i].a, dv[i].b, 1'b0, res, lat, stallCnt, doneStall);
      vectors++;
      if (res !== dv[i].exp) begin
        miscompares++;
        $display("[TB] FAIL dir%0d %s result: got %h, expected %h", i, dv[i].op.name(), res, dv[i].exp);
      end
      vectors++;
      if (lat != dv[i].lat) begin
        miscompares++;
        $display("[TB] FAIL dir%0d latency: got %0d, expected %0d", i, lat, dv[i].lat);
      end
      vectors++;
      if (stallCnt != dv[i].lat) begin
        miscompares++;
        $display("[TB] FAIL dir%0d stall cycles: got %0d, expected %0d", i, stallCnt, dv[i].lat);
      end
      vectors++;
      if (doneStall !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL dir%0d stall_o in result cycle: got %b, expected 0", i, doneStall);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, res, exp;
    md_oper_t    op;
    int          lat, stallCnt, expLat;
    logic        doneStall;
    for (int n = 0; n < 40; n++) begin
      op     = pickOper();
      a      = pickOperand();
      b      = pickOperand();
      exp    = refModel(op, a, b);
      expLat = refLatency(op, a, b);
      issue(op, a, b, 1'b1, res, lat, stallCnt, doneStall);
      vectors++;
      if (res !== exp) begin
        miscompares++;
        $display("[TB] FAIL rnd%0d %s %h,%h result: got %h, expected %h", n, op.name(), a, b, res, exp);
      end
      vectors++;
      if (lat != expLat) begin
        miscompares++;
        $display("[TB] FAIL rnd%0d latency: got %0d, expected %0d", n, lat, expLat);
      end
      vectors++;
      if (stallCnt != expLat) begin
        miscompares++;
        $display("[TB] FAIL rnd%0d stall cycles: got %0d, expected %0d", n, stallCnt, expLat);
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] a, b, res, exp;
    int          lat, stallCnt, validSeen;
    logic        doneStall;
    a = 32'($urandom());
    b = 32'($urandom_range(1, 1000));
    bus.req_valid_i = 1'b1;
    bus.md_oper_i   = MD_DIV;
    bus.operand1_i  = a;
    bus.operand2_i  = b;
    tick();
    bus.req_valid_i = 1'b0;
    repeat (9) tick();
    vectors++;
    if (bus.busy_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL flush busy_o before flush: got %b, expected 1", bus.busy_o);
    end
    bus.flush_i = 1'b1;
    #1;
    vectors++;
    if (bus.stall_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush stall_o: got %b, expected 0", bus.stall_o);
    end
    tick();
    bus.flush_i = 1'b0;
    vectors++;
    if (bus.busy_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush busy_o after flush: got %b, expected 0", bus.busy_o);
    end
    validSeen = 0;
    repeat (30) begin
      if (bus.result_valid_o) validSeen++;
      tick();
    end
    vectors++;
    if (validSeen != 0) begin
      miscompares++;
      $display("[TB] FAIL flush result_valid_o cycles: got %0d, expected 0", validSeen);
    end

    a   = 32'($urandom());
    b   = 32'($urandom_range(1, 1 << 20));
    exp = refModel(MD_DIV, a, b);
    issue(MD_DIV, a, b, 1'b0, res, lat, stallCnt, doneStall);
    vectors++;
    if (res !== exp) begin
      miscompares++;
      $display("[TB] FAIL div after flush: got %h, expected %h", res, exp);
    end
    vectors++;
    if (lat != 33) begin
      miscompares++;
      $display("[TB] FAIL div after flush latency: got %0d, expected 33", lat);
    end

    bus.req_valid_i = 1'b1;
    bus.md_oper_i   = MD_MUL;
    bus.flush_i     = 1'b1;
    #1;
    vectors++;
    if (bus.stall_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush with request stall_o: got %b, expected 0", bus.stall_o);
    end
    tick();
    bus.req_valid_i = 1'b0;
    bus.flush_i     = 1'b0;
    vectors++;
    if (bus.busy_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush with request busy_o: got %b, expected 0", bus.busy_o);
    end
  endtask

  task automatic test_stall_ext();
    logic [31:0] a, b, res, exp;
    int          lat, stallCnt;
    logic        doneStall;
    a   = 32'($urandom());
    b   = 32'($urandom());
    exp = refModel(MD_MULH, a, b);
    bus.stall_ext_i = 1'b1;
    issue(MD_MULH, a, b, 1'b0, res, lat, stallCnt, doneStall);
    vectors++;
    if (res !== exp) begin
      miscompares++;
      $display("[TB] FAIL stall_ext result: got %h, expected %h", res, exp);
    end
    for (int k = 0; k < 3; k++) begin
      bus.req_valid_i = 1'b1;
      bus.md_oper_i   = MD_DIVU;
      bus.operand1_i  = 32'($urandom());
      bus.operand2_i  = 32'd0;
      #1;
      vectors++;
      if (bus.result_valid_o !== 1'b1 || bus.result_o !== exp) begin
        miscompares++;
        $display("[TB] FAIL stall_ext hold%0d: got valid %b data %h, expected valid 1 data %h",
                 k, bus.result_valid_o, bus.result_o, exp);
      end
      vectors++;
      if (bus.stall_o !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL stall_ext hold%0d stall_o: got %b, expected 0", k, bus.stall_o);
      end
      bus.req_valid_i = 1'b0;
      tick();
    end
    bus.stall_ext_i = 1'b0;
    tick();
    vectors++;
    if (bus.busy_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stall_ext release busy_o: got %b, expected 0", bus.busy_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, res, exp;
    md_oper_t    ops[4];
    int          lat, stallCnt;
    logic        doneStall;
    ops = '{MD_DIVU, MD_MULHU, MD_REM, MD_MUL};
    foreach (ops[i]) begin
      a   = 32'($urandom());
      b   = 32'($urandom_range(1, 32'h7FFF_FFFF));
      exp = refModel(ops[i], a, b);
      issue(ops[i], a, b, 1'b0, res, lat, stallCnt, doneStall);
      vectors++;
      if (res !== exp) begin
        miscompares++;
        $display("[TB] FAIL b2b%0d %s: got %h, expected %h", i, ops[i].name(), res, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.req_valid_i = 1'b1;
    bus.md_oper_i   = MD_MUL;
    bus.operand1_i  = 32'($urandom());
    bus.operand2_i  = 32'($urandom());
    tick();
    bus.req_valid_i = 1'b0;
    repeat (5) tick();
    rstn_i = 1'b0;
    #1;
    vectors++;
    if (bus.busy_o !== 1'b0 || bus.result_valid_o !== 1'b0 ||
        bus.result_o !== 32'd0 || bus.stall_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset mid-CALC: got busy %b valid %b result %h stall %b, expected all 0",
               bus.busy_o, bus.result_valid_o, bus.result_o, bus.stall_o);
    end
    #3;
    rstn_i = 1'b1;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors         = 0;
    miscompares     = 0;
    rstn_i          = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.md_oper_i   = MD_NOP;
    bus.operand1_i  = '0;
    bus.operand2_i  = '0;
    bus.flush_i     = 1'b0;
    bus.stall_ext_i = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_stall_ext();
    test_back_to_back();
    test_reset_mid();
    test_directed();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
